// File: rtl/systolic_matmul.sv
// systolic_matmul: NxN signed matrix multiplier C = A x B using an
// output-stationary wavefront schedule. PE(i,j) accumulates C[i][j] in place
// and consumes k = t-i-j at step t, so a job takes 3N-2 steps.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   start          job request, sampled only while busy=0
//   a_flat/b_flat  operands, element (r,c) at [(r*N+c)*DW +: DW]
//   busy           high while a job is running
//   done           one-cycle pulse when c_flat holds the final result
//   c_flat         result, element (i,j) at [(i*N+j)*ACC_W +: ACC_W]
//   ovf            sticky saturation flag
//
// Optional feature: define SYSTOLIC_MATMUL_SATURATE_EN for saturating
// accumulation with a sticky ovf flag; otherwise sums wrap and ovf is 0.
module systolic_matmul #(
  parameter int unsigned N     = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N*N*DW-1:0]      a_flat,
  input  logic [N*N*DW-1:0]      b_flat,
  output logic                   busy,
  output logic                   done,
  output logic [N*N*ACC_W-1:0]   c_flat,
  output logic                   ovf
);

  localparam int unsigned NN        = N * N;
  localparam int unsigned PW        = 2 * DW;
  localparam int unsigned LAST_STEP = 3 * N - 3;
  localparam int unsigned STEP_W    = $clog2(LAST_STEP + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]              r_state, w_state_nxt;
  logic [STEP_W-1:0]       r_step, w_step_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_done, w_done_nxt;
  logic                    w_accept, w_last;

  logic [N*N*DW-1:0]       r_a, r_b;
  logic signed [ACC_W-1:0] r_acc     [NN];
  logic signed [ACC_W-1:0] w_acc_nxt [NN];
  logic [N*N*ACC_W-1:0]    r_c, w_c_nxt;

  logic signed [DW-1:0]    w_opa, w_opb;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
`ifdef SYSTOLIC_MATMUL_SATURATE_EN
  logic [ACC_W:0]          w_sum;
  logic                    w_clamp;
  logic                    r_ovf;
`endif

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
          w_step_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        if (r_step == STEP_W'(LAST_STEP)) begin
          // Final step retires on the same edge that raises done.
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
          w_step_nxt  = '0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_step_nxt  = r_step + STEP_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Wavefront MAC: each PE matches at most one k for the current step
  always_comb begin
    w_opa      = '0;
    w_opb      = '0;
    w_prod     = '0;
    w_prod_ext = '0;
    w_c_nxt    = '0;
`ifdef SYSTOLIC_MATMUL_SATURATE_EN
    w_sum      = '0;
    w_clamp    = 1'b0;
`endif
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        w_acc_nxt[i*N+j] = r_acc[i*N+j];
        for (int k = 0; k < int'(N); k++) begin
          if (r_step == STEP_W'(i + j + k)) begin
            w_opa      = r_a[(i*N+k)*DW +: DW];
            w_opb      = r_b[(k*N+j)*DW +: DW];
            w_prod     = PW'(w_opa) * PW'(w_opb);
            w_prod_ext = ACC_W'(w_prod);
`ifdef SYSTOLIC_MATMUL_SATURATE_EN
            // One guard bit: overflow when the top two sum bits disagree.
            w_sum = {r_acc[i*N+j][ACC_W-1], r_acc[i*N+j]} +
                    {w_prod_ext[ACC_W-1], w_prod_ext};
            if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
              w_clamp          = 1'b1;
              w_acc_nxt[i*N+j] = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                              : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
              w_acc_nxt[i*N+j] = w_sum[ACC_W-1:0];
            end
`else
            w_acc_nxt[i*N+j] = r_acc[i*N+j] + w_prod_ext;
`endif
          end
        end
        w_c_nxt[(i*N+j)*ACC_W +: ACC_W] = w_acc_nxt[i*N+j];
      end
    end
  end

  // Operand capture, accumulators and held result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      for (int n = 0; n < int'(NN); n++) r_acc[n] <= '0;
    end else if (w_accept) begin
      r_a <= a_flat;
      r_b <= b_flat;
      r_c <= '0;
      for (int n = 0; n < int'(NN); n++) r_acc[n] <= '0;
    end else if (r_busy) begin
      for (int n = 0; n < int'(NN); n++) r_acc[n] <= w_acc_nxt[n];
      if (w_last) r_c <= w_c_nxt;
    end
  end

`ifdef SYSTOLIC_MATMUL_SATURATE_EN
  // Sticky clamp flag, cleared per job
  always_ff @(posedge clk) begin
    if (reset || w_accept) r_ovf <= 1'b0;
    else if (r_busy && w_clamp) r_ovf <= 1'b1;
  end
  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign busy   = r_busy;
  assign done   = r_done;
  assign c_flat = r_c;

endmodule

// File: tb/tb_systolic_matmul.sv
// Bench for systolic_matmul: four instances (N=3/ACC_W=20, N=3/ACC_W=16,
// N=2, N=4) driven by directed and random jobs, checked against a plain
// triple-loop matrix product model.
module tb_systolic_matmul;

`ifdef SYSTOLIC_MATMUL_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start_v [4];
  logic [127:0] a_v     [4];
  logic [127:0] b_v     [4];
  logic         busy_v  [4];
  logic         done_v  [4];
  logic         ovf_v   [4];
  logic [179:0] c_0;
  logic [143:0] c_1;
  logic [79:0]  c_2;
  logic [319:0] c_3;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt [4] = '{0, 0, 0, 0};

  systolic_matmul #(.N(3), .DW(8), .ACC_W(20)) u_n3 (
    .clk(clk), .reset(reset), .start(start_v[0]),
    .a_flat(a_v[0][71:0]), .b_flat(b_v[0][71:0]),
    .busy(busy_v[0]), .done(done_v[0]), .c_flat(c_0), .ovf(ovf_v[0]));

  systolic_matmul #(.N(3), .DW(8), .ACC_W(16)) u_n3w16 (
    .clk(clk), .reset(reset), .start(start_v[1]),
    .a_flat(a_v[1][71:0]), .b_flat(b_v[1][71:0]),
    .busy(busy_v[1]), .done(done_v[1]), .c_flat(c_1), .ovf(ovf_v[1]));

  systolic_matmul #(.N(2), .DW(8), .ACC_W(20)) u_n2 (
    .clk(clk), .reset(reset), .start(start_v[2]),
    .a_flat(a_v[2][31:0]), .b_flat(b_v[2][31:0]),
    .busy(busy_v[2]), .done(done_v[2]), .c_flat(c_2), .ovf(ovf_v[2]));

  systolic_matmul #(.N(4), .DW(8), .ACC_W(20)) u_n4 (
    .clk(clk), .reset(reset), .start(start_v[3]),
    .a_flat(a_v[3]), .b_flat(b_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .c_flat(c_3), .ovf(ovf_v[3]));

  // Count done-high cycles per instance
  always @(posedge clk) begin
    for (int q = 0; q < 4; q++) if (done_v[q] === 1'b1) done_cnt[q]++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic int nsel(input int sel);
    case (sel)
      2:       return 2;
      3:       return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int wsel(input int sel);
    return (sel == 1) ? 16 : 20;
  endfunction

  function automatic int get_c(input int sel, input int idx);
    logic [319:0] v;
    logic [31:0]  x;
    int w;
    w = wsel(sel);
    case (sel)
      0:       v = 320'(c_0);
      1:       v = 320'(c_1);
      2:       v = 320'(c_2);
      default: v = c_3;
    endcase
    v = v >> (idx * w);
    x = v[31:0] << (32 - w);
    return $signed(x) >>> (32 - w);
  endfunction

  function automatic logic [127:0] pack(input int n, input int m [16]);
    logic [127:0] v;
    v = '0;
    for (int idx = 0; idx < n * n; idx++) v[idx*8 +: 8] = 8'(m[idx]);
    return v;
  endfunction

  // Reference: sum over k in increasing order, wrapping or clamping per add.
  function automatic void model(input int n, input int w, input int a [16],
                                input int b [16], output int c [16], output int ov);
    longint acc, lo, hi, span;
    span = longint'(1) << w;
    hi   = (longint'(1) << (w - 1)) - 1;
    lo   = -(longint'(1) << (w - 1));
    ov   = 0;
    for (int idx = 0; idx < 16; idx++) c[idx] = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        acc = 0;
        for (int k = 0; k < n; k++) begin
          acc += longint'(a[i*n+k]) * longint'(b[k*n+j]);
          if (SAT) begin
            if (acc > hi) begin acc = hi; ov = 1; end
            else if (acc < lo) begin acc = lo; ov = 1; end
          end else begin
            if (acc > hi) acc -= span;
            else if (acc < lo) acc += span;
          end
        end
        c[i*n+j] = int'(acc);
      end
    end
  endfunction

  function automatic void fill(output int m [16], input int v);
    for (int idx = 0; idx < 16; idx++) m[idx] = v;
  endfunction

  function automatic void rnd(output int m [16], input int lo, input int hi);
    for (int idx = 0; idx < 16; idx++)
      m[idx] = lo + int'($urandom_range(32'(hi - lo)));
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input string tag, input int sel, input int a [16], input int b [16]);
    a_v[sel]     = pack(nsel(sel), a);
    b_v[sel]     = pack(nsel(sel), b);
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    chk({tag, " busy after start"}, int'(busy_v[sel]), 1);
    chk({tag, " done after start"}, int'(done_v[sel]), 0);
    chk({tag, " c cleared"}, get_c(sel, 0), 0);
  endtask

  task automatic wait_done(input string tag, input int sel, input int exp_lat);
    int lat = 0;
    int bc  = 0;
    while (done_v[sel] !== 1'b1 && lat < 300) begin
      if (busy_v[sel] === 1'b1) bc++;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy cycles"}, bc, exp_lat);
    chk({tag, " busy at done"}, int'(busy_v[sel]), 0);
  endtask

  task automatic check_result(input string tag, input int sel, input int a [16], input int b [16]);
    int c [16];
    int ov;
    model(nsel(sel), wsel(sel), a, b, c, ov);
    for (int idx = 0; idx < nsel(sel) * nsel(sel); idx++)
      chk($sformatf("%s C[%0d]", tag, idx), get_c(sel, idx), c[idx]);
    chk({tag, " ovf"}, int'(ovf_v[sel]), ov);
  endtask

  initial begin
    int a [16];
    int b [16];
    int a2 [16];
    int b2 [16];
    int junk [16];
    int d0;

    reset = 1'b1;
    for (int q = 0; q < 4; q++) begin
      start_v[q] = 1'b0;
      a_v[q]     = '0;
      b_v[q]     = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int q = 0; q < 4; q++) begin
      chk($sformatf("reset busy %0d", q), int'(busy_v[q]), 0);
      chk($sformatf("reset done %0d", q), int'(done_v[q]), 0);
      chk($sformatf("reset ovf %0d", q), int'(ovf_v[q]), 0);
      chk($sformatf("reset c %0d", q), get_c(q, 0), 0);
    end

    // Identity x {1..9}
    fill(a, 0);
    for (int i = 0; i < 3; i++) a[i*3+i] = 1;
    for (int idx = 0; idx < 9; idx++) b[idx] = idx + 1;
    launch("ident", 0, a, b);
    wait_done("ident", 0, 7);
    check_result("ident", 0, a, b);
    chk("ident C[4] literal", get_c(0, 4), 5);
    chk("ident C[8] literal", get_c(0, 8), 9);
    @(negedge clk);
    chk("ident done one cycle", int'(done_v[0]), 0);
    chk("ident c held", get_c(0, 8), 9);

    // Signed extremes
    fill(a, -128);
    fill(b, -128);
    launch("negneg", 0, a, b);
    wait_done("negneg", 0, 7);
    check_result("negneg", 0, a, b);
    chk("negneg literal", get_c(0, 0), 49152);
    @(negedge clk);
    fill(b, 127);
    launch("negpos", 0, a, b);
    wait_done("negpos", 0, 7);
    check_result("negpos", 0, a, b);
    chk("negpos literal", get_c(0, 5), -48768);
    @(negedge clk);

    // Wrap or saturate at ACC_W=16
    fill(a, -128);
    fill(b, -128);
    launch("w16", 1, a, b);
    wait_done("w16", 1, 7);
    check_result("w16", 1, a, b);
    chk("w16 literal", get_c(1, 0), SAT ? 32767 : -16384);
    chk("w16 ovf literal", int'(ovf_v[1]), SAT ? 1 : 0);
    @(negedge clk);
    rnd(a, -10, 10);
    rnd(b, -10, 10);
    launch("w16 next", 1, a, b);
    chk("w16 ovf cleared by start", int'(ovf_v[1]), 0);
    wait_done("w16 next", 1, 7);
    check_result("w16 next", 1, a, b);
    @(negedge clk);

    // start while busy ignored; input changes mid-run ignored
    d0 = done_cnt[0];
    rnd(a, -128, 127);
    rnd(b, -128, 127);
    launch("ignore", 0, a, b);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      rnd(junk, -128, 127);
      a_v[0]     = pack(3, junk);
      b_v[0]     = pack(3, junk);
      start_v[0] = (cyc == 2 || cyc == 4);
      @(negedge clk);
    end
    start_v[0] = 1'b0;
    wait_done("ignore", 0, 2);
    check_result("ignore", 0, a, b);
    repeat (10) @(negedge clk);
    chk("ignore single done", done_cnt[0] - d0, 1);

    // start in the done cycle is accepted
    rnd(a, -128, 127);
    rnd(b, -128, 127);
    launch("chain1", 0, a, b);
    wait_done("chain1", 0, 7);
    check_result("chain1", 0, a, b);
    rnd(a2, -128, 127);
    rnd(b2, -128, 127);
    launch("chain2", 0, a2, b2);
    wait_done("chain2", 0, 7);
    check_result("chain2", 0, a2, b2);
    @(negedge clk);

    // Reset mid-run aborts without done
    d0 = done_cnt[0];
    rnd(a, -128, 127);
    rnd(b, -128, 127);
    launch("abort", 0, a, b);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy", int'(busy_v[0]), 0);
    chk("abort done", int'(done_v[0]), 0);
    chk("abort c", get_c(0, 0), 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort no done pulse", done_cnt[0] - d0, 0);
    chk("abort idle busy", int'(busy_v[0]), 0);
    rnd(a, -128, 127);
    rnd(b, -128, 127);
    launch("after abort", 0, a, b);
    wait_done("after abort", 0, 7);
    check_result("after abort", 0, a, b);
    @(negedge clk);

    // Random sweep over N=2, N=4, N=3
    for (int r = 0; r < 3; r++) begin
      rnd(a, -128, 127);
      rnd(b, -128, 127);
      launch($sformatf("n2 r%0d", r), 2, a, b);
      wait_done($sformatf("n2 r%0d", r), 2, 4);
      check_result($sformatf("n2 r%0d", r), 2, a, b);
      @(negedge clk);
      rnd(a, -128, 127);
      rnd(b, -128, 127);
      launch($sformatf("n4 r%0d", r), 3, a, b);
      wait_done($sformatf("n4 r%0d", r), 3, 10);
      check_result($sformatf("n4 r%0d", r), 3, a, b);
      @(negedge clk);
      rnd(a, -128, 127);
      rnd(b, -128, 127);
      launch($sformatf("n3 r%0d", r), 0, a, b);
      wait_done($sformatf("n3 r%0d", r), 0, 7);
      check_result($sformatf("n3 r%0d", r), 0, a, b);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_matmul.md
Name: systolic_matmul

Overview:
- Parametrised NxN signed-integer matrix multiplier, C = A x B.
- Uses an output-stationary systolic wavefront schedule: PE(i,j) accumulates C[i][j] in place. Operands are presented internally skewed, so PE(i,j) consumes k = t-i-j at step t.
- Generalises the fixed 3x3 step-sequenced MAC datapath to any N and operand/accumulator width.
- Adds start/busy/done handshake, held results and optional saturation.
- Sits between operand buffers and the result consumer in the accelerator datapath.

Parameters:
- N, 3, matrix dimension (N >= 2)
- DW, 8, signed operand width (two's complement)
- ACC_W, 20, signed accumulator/result width (ACC_W >= 2*DW)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- a_flat  in  N*N*DW  A; element (i,k) at bits [(i*N+k)*DW +: DW]
- b_flat  in  N*N*DW  B; element (k,j) at bits [(k*N+j)*DW +: DW]
- busy  out  1  high while computing
- done  out  1  one-cycle pulse when C is final
- c_flat  out  N*N*ACC_W  C; element (i,j) at bits [(i*N+j)*ACC_W +: ACC_W]
- ovf  out  1  sticky saturation flag (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high, clock clk): busy=0, done=0, c_flat=0, ovf=0, step counter=0, state IDLE.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> IDLE after step 3N-3.
  - No other states.
- Start edge E0 (start=1, busy=0):
  - Capture a_flat/b_flat into internal registers. Later input changes have no effect on the current job.
  - Clear all accumulators, so c_flat reads 0 during RUN.
  - Set busy=1 and step t=0.
- RUN, edges E1..E(3N-2):
  - Each edge executes step t = 0..3N-3. For every (i,j) with 0 <= t-i-j < N, acc[i][j] += A[i][k]*B[k][j], with k = t-i-j.
  - Product is full 2*DW signed, sign-extended to ACC_W. Sum wraps modulo 2^ACC_W unless SATURATE_EN.
  - Each PE receives exactly N products across the run.
- Completion edge E(3N-2), the same edge as the final step: busy<=0, done<=1. done drops on the next edge.
  - Latency from start edge to done high is 3N-2 cycles (7 for N=3).
- c_flat holds the final result until the next accepted start or reset.
- start while busy=1 is ignored: no restart, no capture.
- start=1 during the done-high cycle (busy=0) is accepted. done falls and the new job starts on the same edge.
- start held high continuously gives back-to-back jobs every 3N-1 cycles.
- reset during RUN aborts immediately: all outputs return to reset values and done is never pulsed for the aborted job.
- reset and start high on the same edge: reset wins.
- Combinational path from start to outputs: none. All outputs are registered.

Optional Feature:
- Macro: SYSTOLIC_MATMUL_SATURATE_EN
- Defined:
  - Each accumulate clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] using ACC_W+1-bit overflow detection.
  - Any clamp sets ovf=1 (sticky). ovf is cleared only by reset or an accepted start.
  - A clamped accumulator continues accumulating from the clamped value.
- Not defined: two's-complement wraparound; ovf tied 0.

Test Plan:
- Defaults (N=3, DW=8, ACC_W=20). A = identity, B = {1..9} row-major, start 1 cycle -> done exactly 7 cycles after the start edge; c_flat = {1..9}; busy high for 7 cycles.
- Signed. All A = -128, all B = -128 -> every C = 49152. Next job: A all -128, B all 127 -> every C = -48768.
- Wrap vs saturate (ACC_W=16). All A = B = -128:
  - Macro undefined -> C = -16384, ovf=0.
  - Macro defined -> C = 32767, ovf=1.
  - Next start clears ovf.
- Handshake:
  - start pulsed at cycles 2 and 4 of RUN -> ignored, done once at cycle 7.
  - Inputs changed mid-run -> result unchanged.
  - start asserted in the done cycle -> second job accepted; done again 7 cycles later with the new result.
- Reset mid-run. Assert reset at step 3 -> next edge: busy=0, c_flat=0, no done pulse. Fresh start afterwards -> correct result.
- Param sweep: N=2 and N=4, random DW=8 operands vs golden model -> done after 4 and 10 cycles respectively; all C match.
